// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end for the IF/ID stage.
// Owns the fetch PC and issues one address per cycle to a synchronous
// instruction memory with a 1-cycle read latency. Returned words are queued
// with their PCs in a DEPTH-entry FIFO and presented one per cycle to decode.
// Decode stalls are absorbed by the queue, and an EX redirect flushes all
// queued and in-flight fetches.
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   redirect       flush the queue and load redirect_pc as the new fetch PC
//   redirect_pc    redirect target; bits [1:0] are ignored (word aligned)
//   stall          decode cannot accept the presented instruction this cycle
//   imem_req       an address is issued this cycle
//   imem_addr      instruction memory address (current fetch PC)
//   imem_rdata     memory data for the address issued in the previous cycle
//   if_valid       if_pc/if_instr carry a valid instruction
//   if_pc          PC of the presented instruction (0 when not valid)
//   if_instr       presented instruction (0 when not valid)
//
// Build option:
//   FETCH_BYPASS_EN  when defined, a word returning into an empty queue is
//                    presented in its return cycle, which cuts fetch latency
//                    by one cycle. When undefined, decode is fed only from
//                    the queue registers.
module fetch_queue #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned INS_W = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             stall,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    output logic             if_valid,
    output logic [PC_W-1:0]  if_pc,
    output logic [INS_W-1:0] if_instr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             inflight_q, inflight_d;
    logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic [INS_W-1:0] ins_mem [DEPTH];

    logic [OCC_W-1:0] occupancy_c;
    logic             issue_c;
    logic             fifo_empty_c;
    logic             bypass_c;
    logic             accept_c;
    logic             push_c;
    logic             pop_c;

    // Issue control: an address goes out only while queued plus in-flight
    // words leave room for its return.
    always_comb begin
        occupancy_c  = OCC_W'(count_q) + OCC_W'(inflight_q);
        fifo_empty_c = (count_q == '0);
        issue_c      = !reset && !redirect && (occupancy_c < OCC_W'(DEPTH));
`ifdef FETCH_BYPASS_EN
        bypass_c     = fifo_empty_c && inflight_q && !redirect;
`else
        bypass_c     = 1'b0;
`endif
    end

    // Decode-facing outputs: queue head, or the returning word when bypassing.
    always_comb begin
        if_valid  = 1'b0;
        if_pc     = '0;
        if_instr  = '0;
        imem_req  = issue_c;
        imem_addr = fetch_pc_q;
        if (reset) begin
            imem_addr = '0;
        end else if (!fifo_empty_c) begin
            if_valid = 1'b1;
            if_pc    = pc_mem[rd_ptr_q];
            if_instr = ins_mem[rd_ptr_q];
        end else if (bypass_c) begin
            if_valid = 1'b1;
            if_pc    = inflight_pc_q;
            if_instr = imem_rdata;
        end
    end

    // A bypassed word that decode accepts is consumed directly and never queued.
    always_comb begin
        accept_c = if_valid && !stall;
        pop_c    = accept_c && !fifo_empty_c;
        push_c   = inflight_q && !(bypass_c && accept_c);
    end

    // Next-state logic; redirect discards queue contents and the in-flight fetch.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (redirect) begin
            count_d    = '0;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redirect_pc & ~PC_W'(3);
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            if (issue_c) begin
                fetch_pc_d    = fetch_pc_q + PC_W'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end else begin
                inflight_d = 1'b0;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Queue storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_c && !redirect && !reset) begin
            pc_mem[wr_ptr_q]  <= inflight_pc_q;
            ins_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
